// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the cache-to-memory bus arbiter.
package cache_bus_pkg;

    // Default bus geometry: one cache line per transfer.
    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 512;
    localparam int TAG_W_DEF  = 13;

    // The top tag bit marks the direction. The arbiter never interprets it.
    localparam int   TAG_RW_BIT = TAG_W_DEF - 1;
    localparam logic TAG_READ   = 1'b1;
    localparam logic TAG_WRITE  = 1'b0;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } arb_state_t;

    // Which cache owns the transaction in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mod_rr_pick2.sv
// Combinational two-way round-robin picker for the I-cache and D-cache requests.
import cache_bus_pkg::*;

module mod_rr_pick2 (
    input  logic   i_reqcyc,
    input  logic   d_reqcyc,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);

    // A lone requester wins. On a tie, the side that did not win last time wins.
    always_comb begin
        grant_valid = i_reqcyc | d_reqcyc;
        grant_owner = OWN_I;
        if (i_reqcyc && d_reqcyc) begin
            grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_reqcyc) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mod_mem_arbiter.sv
// Shares the memory bus between the L1 I-cache and the L1 D-cache.
// Only one transaction is in flight at a time. The response returns to the cache that issued the request.
import cache_bus_pkg::*;

module mod_mem_arbiter #(
    parameter int ADDRWIDTH = 64,
    parameter int DATAWIDTH = 512,
    parameter int TAGWIDTH  = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    // I-cache side
    input  logic                 i_reqcyc,
    input  logic [ADDRWIDTH-1:0] i_req,
    input  logic [TAGWIDTH-1:0]  i_reqtag,
    input  logic [DATAWIDTH-1:0] i_reqdata,
    output logic                 i_reqack,
    output logic [DATAWIDTH-1:0] i_resp,
    output logic [TAGWIDTH-1:0]  i_resptag,
    output logic                 i_respcyc,
    input  logic                 i_respack,
    // D-cache side
    input  logic                 d_reqcyc,
    input  logic [ADDRWIDTH-1:0] d_req,
    input  logic [TAGWIDTH-1:0]  d_reqtag,
    input  logic [DATAWIDTH-1:0] d_reqdata,
    output logic                 d_reqack,
    output logic [DATAWIDTH-1:0] d_resp,
    output logic [TAGWIDTH-1:0]  d_resptag,
    output logic                 d_respcyc,
    input  logic                 d_respack,
    // Memory side
    output logic                 m_reqcyc,
    output logic [ADDRWIDTH-1:0] m_req,
    output logic [TAGWIDTH-1:0]  m_reqtag,
    output logic [DATAWIDTH-1:0] m_reqdata,
    input  logic                 m_reqack,
    input  logic [DATAWIDTH-1:0] m_resp,
    input  logic [TAGWIDTH-1:0]  m_resptag,
    input  logic                 m_respcyc,
    output logic                 m_respack
);

    arb_state_t           state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               last_grant_q, last_grant_d;

    logic                 m_reqcyc_q, m_reqcyc_d;
    logic [ADDRWIDTH-1:0] m_req_q, m_req_d;
    logic [TAGWIDTH-1:0]  m_reqtag_q, m_reqtag_d;
    logic [DATAWIDTH-1:0] m_reqdata_q, m_reqdata_d;

    logic                 i_reqack_q, i_reqack_d;
    logic                 d_reqack_q, d_reqack_d;
    logic [DATAWIDTH-1:0] i_resp_q, i_resp_d;
    logic [DATAWIDTH-1:0] d_resp_q, d_resp_d;
    logic [TAGWIDTH-1:0]  i_resptag_q, i_resptag_d;
    logic [TAGWIDTH-1:0]  d_resptag_q, d_resptag_d;
    logic                 i_respcyc_q, i_respcyc_d;
    logic                 d_respcyc_q, d_respcyc_d;

    logic                 grant_valid;
    owner_t               grant_owner;
    logic                 owner_respack;
    logic                 resp_tag_match;

    mod_rr_pick2 u_pick (
        .i_reqcyc    (i_reqcyc),
        .d_reqcyc    (d_reqcyc),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Memory responses are always accepted. A stray response outside WAIT is simply discarded.
    assign m_respack = m_respcyc;

    // m_reqtag_q still holds the tag that was issued, so it serves as the expected response tag.
    assign resp_tag_match = (m_resptag == m_reqtag_q);
    assign owner_respack  = (owner_q == OWN_I) ? i_respack : d_respack;

    // Next-state and next-output logic for the single-transaction FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        m_reqcyc_d   = m_reqcyc_q;
        m_req_d      = m_req_q;
        m_reqtag_d   = m_reqtag_q;
        m_reqdata_d  = m_reqdata_q;
        i_reqack_d   = 1'b0;
        d_reqack_d   = 1'b0;
        i_resp_d     = i_resp_q;
        d_resp_d     = d_resp_q;
        i_resptag_d  = i_resptag_q;
        d_resptag_d  = d_resptag_q;
        i_respcyc_d  = i_respcyc_q;
        d_respcyc_d  = d_respcyc_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_owner == OWN_I) begin
                        i_reqack_d  = 1'b1;
                        m_req_d     = i_req;
                        m_reqtag_d  = i_reqtag;
                        m_reqdata_d = i_reqdata;
                    end else begin
                        d_reqack_d  = 1'b1;
                        m_req_d     = d_req;
                        m_reqtag_d  = d_reqtag;
                        m_reqdata_d = d_reqdata;
                    end
                    m_reqcyc_d   = 1'b1;
                    owner_d      = grant_owner;
                    last_grant_d = grant_owner;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m_reqack) begin
                    m_reqcyc_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Writes wait here for a response too. A response with the wrong tag is dropped.
                if (m_respcyc && resp_tag_match) begin
                    if (owner_q == OWN_I) begin
                        i_resp_d    = m_resp;
                        i_resptag_d = m_resptag;
                        i_respcyc_d = 1'b1;
                    end else begin
                        d_resp_d    = m_resp;
                        d_resptag_d = m_resptag;
                        d_respcyc_d = 1'b1;
                    end
                    state_d = RETURN;
                end
            end
            RETURN: begin
                if (owner_respack) begin
                    i_respcyc_d = 1'b0;
                    d_respcyc_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            m_reqcyc_q   <= 1'b0;
            m_req_q      <= '0;
            m_reqtag_q   <= '0;
            m_reqdata_q  <= '0;
            i_reqack_q   <= 1'b0;
            d_reqack_q   <= 1'b0;
            i_resp_q     <= '0;
            d_resp_q     <= '0;
            i_resptag_q  <= '0;
            d_resptag_q  <= '0;
            i_respcyc_q  <= 1'b0;
            d_respcyc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            m_reqcyc_q   <= m_reqcyc_d;
            m_req_q      <= m_req_d;
            m_reqtag_q   <= m_reqtag_d;
            m_reqdata_q  <= m_reqdata_d;
            i_reqack_q   <= i_reqack_d;
            d_reqack_q   <= d_reqack_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_resptag_q  <= i_resptag_d;
            d_resptag_q  <= d_resptag_d;
            i_respcyc_q  <= i_respcyc_d;
            d_respcyc_q  <= d_respcyc_d;
        end
    end

    // Simulation diagnostic: flag any memory response whose tag differs from the tag that was issued.
    always_ff @(posedge clk) begin
        if (!reset && state_q == WAIT && m_respcyc) begin
            assert (resp_tag_match)
            else $warning("mem response tag %h does not match issued tag %h; response dropped",
                          m_resptag, m_reqtag_q);
        end
    end

    assign m_reqcyc  = m_reqcyc_q;
    assign m_req     = m_req_q;
    assign m_reqtag  = m_reqtag_q;
    assign m_reqdata = m_reqdata_q;
    assign i_reqack  = i_reqack_q;
    assign d_reqack  = d_reqack_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;
    assign i_resptag = i_resptag_q;
    assign d_resptag = d_resptag_q;
    assign i_respcyc = i_respcyc_q;
    assign d_respcyc = d_respcyc_q;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Self-checking bench for mod_mem_arbiter.
// The reference model tracks the pending request on each side and the last winner.
// It predicts grant order, the forwarded request and the routing of each response.
module tb_mod_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int TW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_reqcyc, d_reqcyc;
    logic [AW-1:0] i_req, d_req;
    logic [TW-1:0] i_reqtag, d_reqtag;
    logic [DW-1:0] i_reqdata, d_reqdata;
    logic          i_reqack, d_reqack;
    logic [DW-1:0] i_resp, d_resp;
    logic [TW-1:0] i_resptag, d_resptag;
    logic          i_respcyc, d_respcyc;
    logic          i_respack, d_respack;
    logic          m_reqcyc;
    logic [AW-1:0] m_req;
    logic [TW-1:0] m_reqtag;
    logic [DW-1:0] m_reqdata;
    logic          m_reqack;
    logic [DW-1:0] m_resp;
    logic [TW-1:0] m_resptag;
    logic          m_respcyc;
    logic          m_respack;

    always #5 clk = ~clk;

    mod_mem_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TAGWIDTH(TW)) dut (
        .clk       (clk),       .reset     (reset),
        .i_reqcyc  (i_reqcyc),  .i_req     (i_req),     .i_reqtag  (i_reqtag),
        .i_reqdata (i_reqdata), .i_reqack  (i_reqack),  .i_resp    (i_resp),
        .i_resptag (i_resptag), .i_respcyc (i_respcyc), .i_respack (i_respack),
        .d_reqcyc  (d_reqcyc),  .d_req     (d_req),     .d_reqtag  (d_reqtag),
        .d_reqdata (d_reqdata), .d_reqack  (d_reqack),  .d_resp    (d_resp),
        .d_resptag (d_resptag), .d_respcyc (d_respcyc), .d_respack (d_respack),
        .m_reqcyc  (m_reqcyc),  .m_req     (m_req),     .m_reqtag  (m_reqtag),
        .m_reqdata (m_reqdata), .m_reqack  (m_reqack),  .m_resp    (m_resp),
        .m_resptag (m_resptag), .m_respcyc (m_respcyc), .m_respack (m_respack)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference model state. Side 0 is the I-cache and side 1 is the D-cache.
    bit            pend [2];
    logic [AW-1:0] req_addr [2];
    logic [TW-1:0] req_tag [2];
    logic [DW-1:0] req_data [2];
    bit            last_d;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_req();
        i_reqcyc = pend[0]; i_req = req_addr[0]; i_reqtag = req_tag[0]; i_reqdata = req_data[0];
        d_reqcyc = pend[1]; d_req = req_addr[1]; d_reqtag = req_tag[1]; d_reqdata = req_data[1];
    endtask

    task automatic set_req(input int s, input logic [AW-1:0] a, input logic [TW-1:0] t,
                           input logic [DW-1:0] d);
        pend[s] = 1'b1; req_addr[s] = a; req_tag[s] = t; req_data[s] = d;
        drive_req();
    endtask

    task automatic rand_req(input int s);
        if (!pend[s]) set_req(s, {$urandom, $urandom}, TW'($urandom), rand_line());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_req();
        m_reqack = 1'b0; m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
        i_respack = 1'b0; d_respack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        last_d = 1'b0;
    endtask

    task automatic check_idle_outputs(input string where);
        check({where, "_m_reqcyc"}, m_reqcyc, 1'b0);
        check({where, "_reqacks"}, {i_reqack, d_reqack}, 2'b00);
        check({where, "_respcycs"}, {i_respcyc, d_respcyc}, 2'b00);
        check({where, "_m_req"}, m_req, '0);
        check({where, "_m_reqtag"}, m_reqtag, '0);
        check({where, "_m_reqdata"}, m_reqdata, '0);
        check({where, "_d_resp"}, d_resp, '0);
        check({where, "_i_resptag"}, i_resptag, '0);
    endtask

    // Run one transaction for whichever side the round-robin rule picks. Must be called right after a negedge while the arbiter is idle.
    task automatic serve_one(input int ack_dly, input int resp_dly, input int hold_dly,
                             input bit bad_first, input bit late, input logic [DW-1:0] rdata);
        int            w;
        logic [TW-1:0] rtag;
        if (pend[0] && pend[1]) w = last_d ? 0 : 1;
        else                    w = pend[1] ? 1 : 0;

        @(negedge clk);
        check("grant_i_reqack", i_reqack, logic'(w == 0));
        check("grant_d_reqack", d_reqack, logic'(w == 1));
        check("issue_m_reqcyc", m_reqcyc, 1'b1);
        check("issue_m_req", m_req, req_addr[w]);
        check("issue_m_reqtag", m_reqtag, req_tag[w]);
        check("issue_m_reqdata", m_reqdata, req_data[w]);
        pend[w] = 1'b0;
        last_d  = (w == 1);
        drive_req();
        if (late) rand_req(1 - w);

        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            check("issue_ack_pulse", {i_reqack, d_reqack}, 2'b00);
            check("issue_hold_cyc", m_reqcyc, 1'b1);
            check("issue_hold_req", m_req, req_addr[w]);
            check("issue_hold_tag", m_reqtag, req_tag[w]);
            check("issue_hold_data", m_reqdata, req_data[w]);
        end
        m_reqack = 1'b1;
        @(negedge clk);
        m_reqack = 1'b0;
        check("wait_m_reqcyc", m_reqcyc, 1'b0);
        check("wait_ack_pulse", {i_reqack, d_reqack}, 2'b00);

        for (int k = 0; k < resp_dly; k++) begin
            @(negedge clk);
            check("wait_no_respcyc", {i_respcyc, d_respcyc}, 2'b00);
        end
        rtag = req_tag[w];
        if (bad_first) begin
            m_respcyc = 1'b1; m_resptag = rtag ^ TW'(1); m_resp = ~rdata;
            #1 check("bad_m_respack", m_respack, 1'b1);
            @(negedge clk);
            check("bad_dropped", {i_respcyc, d_respcyc}, 2'b00);
        end
        m_respcyc = 1'b1; m_resptag = rtag; m_resp = rdata;
        #1 check("resp_m_respack", m_respack, 1'b1);
        @(negedge clk);
        m_respcyc = 1'b0; m_resptag = '0; m_resp = '0;
        #1 check("idle_m_respack", m_respack, 1'b0);
        check("ret_i_respcyc", i_respcyc, logic'(w == 0));
        check("ret_d_respcyc", d_respcyc, logic'(w == 1));
        check("ret_resp", (w == 0) ? i_resp : d_resp, rdata);
        check("ret_resptag", (w == 0) ? i_resptag : d_resptag, rtag);

        for (int k = 0; k < hold_dly; k++) begin
            @(negedge clk);
            check("ret_hold_cyc", {i_respcyc, d_respcyc}, (w == 0) ? 2'b10 : 2'b01);
            check("ret_hold_resp", (w == 0) ? i_resp : d_resp, rdata);
        end
        if (w == 0) i_respack = 1'b1; else d_respack = 1'b1;
        @(negedge clk);
        i_respack = 1'b0; d_respack = 1'b0;
        check("done_respcyc", {i_respcyc, d_respcyc}, 2'b00);
        n_txn++;
        $display("txn %0d owner=%s addr=%h tag=%h ackdly=%0d respdly=%0d",
                 n_txn, (w == 0) ? "I" : "D", req_addr[w], rtag, ack_dly, resp_dly);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_addr[s] = '0; req_tag[s] = '0; req_data[s] = '0;
        end
        do_reset();
        check_idle_outputs("reset");

        // D-only read, memory ack after 2 cycles, response after 3 more. The I side must stay quiet.
        set_req(1, 64'h1000, 13'h1000, '0);
        serve_one(2, 3, 0, 1'b0, 1'b0, {16{32'hABABABAB}});
        check("t1_i_resp", i_resp, '0);
        check("t1_i_resptag", i_resptag, '0);

        // Simultaneous I and D requests after reset: D wins, I wins next, then D again.
        do_reset();
        set_req(0, 64'h3000, 13'h1111, '0);
        set_req(1, 64'h4000, 13'h1222, '0);
        serve_one(0, 0, 1, 1'b0, 1'b0, rand_line());
        serve_one(1, 1, 0, 1'b0, 1'b0, rand_line());
        rand_req(0); rand_req(1);
        serve_one(0, 2, 0, 1'b0, 1'b0, rand_line());
        serve_one(0, 0, 0, 1'b0, 1'b0, rand_line());

        // D write: the write data passes to memory unchanged, and the write still completes on a response.
        set_req(1, 64'h2040, 13'h0800, {16{32'h55555555}});
        serve_one(1, 2, 0, 1'b0, 1'b0, rand_line());

        // Memory holds off its request ack for 10 cycles.
        rand_req(0);
        serve_one(10, 1, 0, 1'b0, 1'b0, rand_line());

        // A response with the wrong tag is dropped. The one with the right tag is then delivered.
        set_req(1, 64'h1000, 13'h1000, '0);
        serve_one(1, 1, 0, 1'b1, 1'b0, rand_line());

        // Randomised traffic with random memory and requester latencies.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 1) == 1) rand_req(0);
            if ($urandom_range(0, 1) == 1) rand_req(1);
            if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(0, 1)));
            serve_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b0, bit'($urandom_range(0, 1)), rand_line());
        end
        while (pend[0] || pend[1]) serve_one(0, 0, 0, 1'b0, 1'b0, rand_line());

        // Reset while waiting for memory. The late response is acked and discarded, and arbitration restarts with D first.
        set_req(1, 64'h5000, 13'h0A5A, '0);
        @(negedge clk);
        check("t6_grant", d_reqack, 1'b1);
        pend[1] = 1'b0; drive_req();
        m_reqack = 1'b1;
        @(negedge clk);
        m_reqack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_d = 1'b0;
        check_idle_outputs("t6_reset");
        @(negedge clk);
        m_respcyc = 1'b1; m_resptag = 13'h0A5A; m_resp = rand_line();
        #1 check("t6_stale_m_respack", m_respack, 1'b1);
        @(negedge clk);
        m_respcyc = 1'b0; m_resptag = '0; m_resp = '0;
        check("t6_stale_respcyc", {i_respcyc, d_respcyc}, 2'b00);
        @(negedge clk);
        check("t6_still_idle", {i_respcyc, d_respcyc, m_reqcyc}, 3'b000);
        rand_req(0); rand_req(1);
        serve_one(1, 1, 0, 1'b0, 1'b0, rand_line());
        serve_one(0, 1, 1, 1'b0, 1'b0, rand_line());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
